// File: rtl/pulse_meter_if.sv
// Pulse meter bundle: the sampled pulse input plus the measurement results.
// Modports: slave = meter side (takes sig, drives results); master = source/observer side.
interface pulse_meter_if #(
    parameter int W = 8
);
    logic         sig;
    logic [W-1:0] width;
    logic [W-1:0] period;
    logic         valid;
    logic         ovf;
    logic         timeout;
    logic         busy;

    modport slave (
        input  sig,
        output width, period, valid, ovf, timeout, busy
    );

    modport master (
        output sig,
        input  width, period, valid, ovf, timeout, busy
    );
endinterface

// File: rtl/pulse_meter.sv
// Pulse meter: synchronizes an async pulse train and measures high width and
// rise-to-rise period in clk cycles, strobing valid per completed pulse.
// Ports: clk, reset (async, active-high), pm (pulse_meter_if.slave):
//   sig in; width/period/ovf held until next valid; valid/timeout strobes; busy.
// Optional: define GLITCH_FILTER_EN to discard pulses narrower than MIN_WIDTH.
module pulse_meter #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 2
) (
    input  logic          clk,
    input  logic          reset,
    pulse_meter_if.slave  pm
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] MAX   = '1;
    localparam logic [W-1:0] MIN_W = W'(MIN_WIDTH);

`ifdef GLITCH_FILTER_EN
    localparam logic FILT_EN = 1'b1;
`else
    localparam logic FILT_EN = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;
    state_t                 state_q, state_d;
    logic [W-1:0]           hcnt_q, hcnt_d;
    logic [W-1:0]           pcnt_q, pcnt_d;
    logic                   sat_q, sat_d;
    logic [W-1:0]           wr_q, wr_d;
    logic [W-1:0]           width_q, width_d;
    logic [W-1:0]           period_q, period_d;
    logic                   ovf_q, ovf_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;

    logic         s, rise, fall, glitch;
    logic [W-1:0] hinc, pinc;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], pm.sig};
    assign s      = sync_q[SYNC_STAGES-1];
    assign s_d_d  = s;
    assign rise   = s & ~s_d_q;
    assign fall   = ~s & s_d_q;

    // Counters saturate instead of wrapping.
    assign hinc = (hcnt_q == MAX) ? MAX : hcnt_q + ONE;
    assign pinc = (pcnt_q == MAX) ? MAX : pcnt_q + ONE;

    // Too-short pulse; only acted on when the filter is built in.
    assign glitch = FILT_EN & fall & (hcnt_q < MIN_W);

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        pcnt_d    = pcnt_q;
        sat_d     = sat_q;
        wr_d      = wr_q;
        width_d   = width_q;
        period_d  = period_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_HIGH;
                    hcnt_d  = ONE;
                    pcnt_d  = ONE;
                    sat_d   = 1'b0;
                end
            end
            S_HIGH: begin
                if (glitch) begin
                    state_d = S_IDLE;
                end else if (fall) begin
                    wr_d    = hcnt_q;
                    pcnt_d  = pinc;
                    sat_d   = sat_q | (pinc == MAX);
                    state_d = S_LOW;
                end else begin
                    hcnt_d = hinc;
                    pcnt_d = pinc;
                    sat_d  = sat_q | (hinc == MAX) | (pinc == MAX);
                    if (pinc == MAX) begin
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_LOW: begin
                if (rise) begin
                    width_d  = wr_q;
                    period_d = pcnt_q;
                    ovf_d    = sat_q;
                    valid_d  = 1'b1;
                    hcnt_d   = ONE;
                    pcnt_d   = ONE;
                    sat_d    = 1'b0;
                    state_d  = S_HIGH;
                end else begin
                    pcnt_d = pinc;
                    sat_d  = sat_q | (pinc == MAX);
                    if (pinc == MAX) begin
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            s_d_q     <= 1'b0;
            state_q   <= S_IDLE;
            hcnt_q    <= '0;
            pcnt_q    <= '0;
            sat_q     <= 1'b0;
            wr_q      <= '0;
            width_q   <= '0;
            period_q  <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            s_d_q     <= s_d_d;
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            pcnt_q    <= pcnt_d;
            sat_q     <= sat_d;
            wr_q      <= wr_d;
            width_q   <= width_d;
            period_q  <= period_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign pm.width   = width_q;
    assign pm.period  = period_q;
    assign pm.ovf     = ovf_q;
    assign pm.valid   = valid_q;
    assign pm.timeout = timeout_q;
    assign pm.busy    = (state_q != S_IDLE);

endmodule

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
- Receive-side counterpart of the periodic pulse generator: samples a pulse train on a single-bit input and measures, in `clk` cycles, the high width and the rising-to-rising period of each pulse.
- Each complete measurement is reported with a one-cycle `valid` strobe.
- Used in benches and designs to check generated pulse trains against expected timing.
- Stuck or over-long signals are flagged, never hung on.

Parameters:
- W, 8, width of the width/period counters and outputs; maximum count 2^W-1.
- SYNC_STAGES, 2, synchronizer flops on `sig` before edge detection (minimum 2).
- MIN_WIDTH, 2, minimum accepted high width in cycles; used only when GLITCH_FILTER_EN is defined.

Ports:
- clk      input   1  rising-edge clock
- reset    input   1  asynchronous, active-high reset
- sig      input   1  pulse input, asynchronous to `clk`
- width    output  W  high width of last completed pulse, in cycles
- period   output  W  rising-to-rising distance of last completed pulse, in cycles
- valid    output  1  one-cycle strobe: `width`/`period` updated this cycle
- ovf      output  1  qualified by `valid`: a counter saturated during this measurement
- timeout  output  1  one-cycle strobe: no edge for 2^W-1 cycles, measurement abandoned
- busy     output  1  high when FSM is not in IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Synchronizer:
  - `sig` passes through SYNC_STAGES flops to give `s`, then one more flop gives `s_d`.
  - rise = s & ~s_d; fall = ~s & s_d.
  - An input edge is acted on SYNC_STAGES+1 clock edges after it is first sampled.
- Reset:
  - All sync flops, counters, `width`, `period`, `valid`, `ovf`, `timeout` and `busy` go to 0; FSM goes to IDLE.
  - Reset mid-measurement discards the partial measurement; no strobe is emitted.
  - If `sig` is high through reset, a rise is detected after deassertion (`s_d` resets to 0). This is intended.
- Counters `hcnt` and `pcnt`, W bits, saturate at 2^W-1 and never wrap. A sticky `sat` bit is set on any saturation.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: on rise -> HIGH; hcnt=1, pcnt=1, sat=0.
  - HIGH, no fall: hcnt++ and pcnt++ (saturating).
  - HIGH, fall: latch w_r=hcnt; pcnt++; -> LOW.
  - LOW, no rise: pcnt++.
  - LOW, rise:
    - width<=w_r, period<=pcnt, ovf<=sat, valid=1 for this cycle.
    - Restart with hcnt=1, pcnt=1, sat=0; -> HIGH.
    - Back-to-back pulses are measured with no dead cycle.
  - HIGH or LOW, pcnt reaches 2^W-1 with no qualifying edge in that cycle: timeout=1 for one cycle; -> IDLE; `width`/`period` unchanged.
- Resulting definitions:
  - width = number of cycles `s` was high.
  - period = number of cycles from one detected rise to the next.
- Outputs:
  - `width`, `period` and `ovf` hold their value until the next `valid`.
  - `valid` and `timeout` are never high in the same cycle.
  - busy = (state != IDLE).
- Rise and fall cannot occur in the same cycle (single `s` bit).
- The first pulse after IDLE produces no `valid` until its following rise.

Optional Feature:
- Macro: GLITCH_FILTER_EN.
- Defined: in HIGH, a fall with hcnt < MIN_WIDTH discards the pulse.
  - FSM -> IDLE; no `valid`, no `timeout`; `width`/`period` unchanged.
  - The next rise starts a fresh measurement.
- Not defined: any high width >= 1 is measured; MIN_WIDTH is ignored.
- The port list is identical in both builds.

Test Plan:
- Reset, then `sig` high 3 cycles / low 5 cycles, repeated -> from the 2nd rise onward, `valid` once per 8 cycles with width=3, period=8, ovf=0; busy=1 after the first rise.
- `sig` high 1 cycle / low 1 cycle, no filter -> valid every 2 cycles, width=1, period=2.
- `sig` held low after one rise/fall (W=8) -> timeout pulse exactly 254 cycles after the rise; busy=0 next cycle; width/period unchanged; no valid.
- Assert `reset` for 1 cycle during LOW of a pulse 4 high / 6 low -> all outputs 0 immediately; first valid after release reports width=4, period=10.
- With GLITCH_FILTER_EN and MIN_WIDTH=2: pulses 4 high / 6 low with one 1-cycle glitch inserted between them -> no valid spanning the glitch, FSM returns to IDLE; subsequent valids report width=4, period=10.
- W=4: `sig` high 20 cycles then low 2 -> FSM times out in HIGH at pcnt=15: timeout=1, no valid.
